av_eth_cfg_loader: RTL and testbench
====================================

// Module: av_eth_cfg_loader
// PURPOSE
//  Avalon-MM master that loads the Ethernet/UDP configuration register file (9 x 32-bit words) from parallel inputs.
//  It can then read each word back and compare it. Sits between a boot/control FSM and the config slave on the same clk.
//  Reports busy, done, error code and the first failing word address.
// PARAMETERS
//  NUM_REGS      9    words transferred, addresses 0..NUM_REGS-1
//  READ_LATENCY  1    fixed cycles from read accept to valid readdata (legal 1..4)
//  TIMEOUT       255  max consecutive waitrequest cycles per transfer before abort
// PORTS
//  clk            in   1   system clock
//  reset          in   1   async, active-high reset
//  start          in   1   1-cycle pulse; begins a load sequence when idle
//  verify_en      in   1   sampled with start; 1 = read-back/compare phase after writes
//  checksum_i     in   16  word 0, zero-extended to 32 bits
//  local_port_i   in   16  word 1, zero-extended
//  remote_port_i  in   16  word 2, zero-extended
//  local_IP_i     in   32  word 3
//  remote_IP_i    in   32  word 4
//  local_MAC_i    in   48  word 5 = [31:0]; word 6 = {16'h0,[47:32]}
//  remote_MAC_i   in   48  word 7 = [31:0]; word 8 = {16'h0,[47:32]}
//  address        out  4   Avalon word address
//  write          out  1   Avalon write request
//  read           out  1   Avalon read request
//  writedata      out  32  Avalon write data
//  readdata       in   32  Avalon read data, valid READ_LATENCY cycles after accept
//  waitrequest    in   1   Avalon stall; a request is accepted on a cycle where it is asserted and waitrequest=0
//  busy           out  1   high from the cycle after start until done
//  done           out  1   1-cycle completion pulse (success or error)
//  err_code       out  2   0 none, 1 readback mismatch, 2 waitrequest timeout; held until next start
//  err_addr       out  4   word address of the first error; held until next start
// BEHAVIOUR
//  Reset values: all outputs 0. State = IDLE, word index = 0, timeout counter = 0.
//  Snapshot: on start in IDLE, capture all *_i inputs and verify_en into internal regs.
//    Clear err_code and err_addr. Changes to the inputs during the sequence have no effect.
//  start while busy: ignored.
//  FSM states:
//  - IDLE -> WR on start.
//  - WR: write=1, address=idx, writedata=snap[idx]. Hold all three stable while waitrequest=1.
//    On accept: if idx==NUM_REGS-1, go to RD with idx=0 when verify_en, else go to FIN. Otherwise idx++.
//  - RD: read=1, address=idx, held while waitrequest=1. On accept -> RWAIT.
//  - RWAIT: count READ_LATENCY cycles, then sample readdata and compare with snap[idx].
//    Mismatch: err_code=1, err_addr=idx, go to FIN (abort).
//    Match: if idx==NUM_REGS-1 go to FIN, else idx++ and go to RD.
//  - FIN: done=1 for exactly one cycle, busy=0, go to IDLE.
//  write and read are never asserted in the same cycle. Back-to-back writes are allowed with no idle cycle between them.
//  Timeout: the counter increments each cycle a request is stalled by waitrequest and clears on accept.
//    When it reaches TIMEOUT: err_code=2, err_addr=idx, request dropped the next cycle, go to FIN.
//  Reset mid-sequence: returns to IDLE immediately. No done pulse. The partial load is not resumed.
//  idx is 4 bits and never wraps past NUM_REGS-1. Addresses >= NUM_REGS are never issued.
// STRUCTURE
//  Shared package eth_cfg_pkg:
//  - word index constants: CFG_CHECKSUM=0 .. CFG_RMAC_MSB=8
//  - CFG_NUM_REGS
//  - err_code constants
//  - state encoding
//  Single flat module. The snapshot word mux (idx -> 32-bit word) is a function in the package. No sub-module.
// TESTING
//  1 Reset, start, verify_en=0, waitrequest=0, local_IP_i=C0A80004 -> 9 consecutive writes, addr 0..8.
//    Word 3 = C0A80004. Word 6 = 000074EA for local_MAC_i=74EA3A851BD7. done pulses at cycle 10.
//  2 verify_en=1 with the config slave model -> 9 writes, then 9 reads with 1-cycle latency.
//    done pulses, err_code=0.
//  3 Slave corrupts word 4 readback (C0A80006) -> err_code=1, err_addr=4.
//    No read issued to addr 5. done pulses once.
//  4 waitrequest=1 for 3 cycles on write 2 -> address, write and writedata held stable. Sequence completes, err_code=0.
//  5 waitrequest stuck at 1 on write 0 -> after 255 stall cycles, err_code=2, err_addr=0, done pulses.
//  6 reset asserted during write 5, start pulses while busy -> outputs 0 immediately, no done.
//    A start pulsed while busy produces no second sequence.

Source files
------------

// File: rtl/eth_cfg_pkg.sv
// eth_cfg_pkg: shared word map, error codes, FSM encoding and snapshot word mux for the config loader
package eth_cfg_pkg;

    localparam logic [3:0] CFG_CHECKSUM  = 4'd0;
    localparam logic [3:0] CFG_LPORT     = 4'd1;
    localparam logic [3:0] CFG_RPORT     = 4'd2;
    localparam logic [3:0] CFG_LIP       = 4'd3;
    localparam logic [3:0] CFG_RIP       = 4'd4;
    localparam logic [3:0] CFG_LMAC_LSB  = 4'd5;
    localparam logic [3:0] CFG_LMAC_MSB  = 4'd6;
    localparam logic [3:0] CFG_RMAC_LSB  = 4'd7;
    localparam logic [3:0] CFG_RMAC_MSB  = 4'd8;

    localparam int CFG_NUM_REGS = 9;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISMATCH = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

    typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_RD, ST_RWAIT, ST_FIN} state_t;

    typedef struct packed {
        logic [15:0] checksum;
        logic [15:0] local_port;
        logic [15:0] remote_port;
        logic [31:0] local_ip;
        logic [31:0] remote_ip;
        logic [47:0] local_mac;
        logic [47:0] remote_mac;
    } cfg_snap_t;

    function automatic logic [31:0] cfg_word(input cfg_snap_t s, input logic [3:0] idx);
        case (idx)
            CFG_CHECKSUM: cfg_word = {16'h0, s.checksum};
            CFG_LPORT:    cfg_word = {16'h0, s.local_port};
            CFG_RPORT:    cfg_word = {16'h0, s.remote_port};
            CFG_LIP:      cfg_word = s.local_ip;
            CFG_RIP:      cfg_word = s.remote_ip;
            CFG_LMAC_LSB: cfg_word = s.local_mac[31:0];
            CFG_LMAC_MSB: cfg_word = {16'h0, s.local_mac[47:32]};
            CFG_RMAC_LSB: cfg_word = s.remote_mac[31:0];
            CFG_RMAC_MSB: cfg_word = {16'h0, s.remote_mac[47:32]};
            default:      cfg_word = 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/av_eth_cfg_loader.sv
// av_eth_cfg_loader: Avalon-MM master writing the 9-word Ethernet/UDP config and optionally reading it back
module av_eth_cfg_loader
    import eth_cfg_pkg::*;
#(
    parameter int NUM_REGS     = CFG_NUM_REGS,
    parameter int READ_LATENCY = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        verify_en,
    input  logic [15:0] checksum_i,
    input  logic [15:0] local_port_i,
    input  logic [15:0] remote_port_i,
    input  logic [31:0] local_IP_i,
    input  logic [31:0] remote_IP_i,
    input  logic [47:0] local_MAC_i,
    input  logic [47:0] remote_MAC_i,
    output logic [3:0]  address,
    output logic        write,
    output logic        read,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    input  logic        waitrequest,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code,
    output logic [3:0]  err_addr
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state, state_n;
    cfg_snap_t     snap;
    logic          verify;
    logic [3:0]    idx;
    logic [TW-1:0] tcnt;
    logic [2:0]    lcnt;
    logic [31:0]   word;
    logic          req, accept, stall, tmo, last, rd_sample, mismatch;

    assign word      = cfg_word(snap, idx);
    assign req       = state == ST_WR || state == ST_RD;
    assign accept    = req && !waitrequest;
    assign stall     = req && waitrequest;
    assign tmo       = stall && tcnt == TW'(TIMEOUT - 1);
    assign last      = idx == 4'(NUM_REGS - 1);
    assign rd_sample = state == ST_RWAIT && lcnt == 3'(READ_LATENCY - 1);
    assign mismatch  = rd_sample && readdata != word;
    assign address   = req ? idx : 4'd0;
    assign writedata = state == ST_WR ? word : 32'd0;

    // state register; reset abandons any partial load without a done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    // next state and Moore bus/status outputs
    always_comb begin
        state_n = state;
        write   = 1'b0;
        read    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            ST_IDLE:  state_n = start ? ST_WR : ST_IDLE;
            ST_WR: begin
                write   = 1'b1;
                busy    = 1'b1;
                state_n = tmo ? ST_FIN : (accept && last) ? (verify ? ST_RD : ST_FIN) : ST_WR;
            end
            ST_RD: begin
                read    = 1'b1;
                busy    = 1'b1;
                state_n = tmo ? ST_FIN : accept ? ST_RWAIT : ST_RD;
            end
            ST_RWAIT: begin
                busy    = 1'b1;
                state_n = !rd_sample ? ST_RWAIT : (mismatch || last) ? ST_FIN : ST_RD;
            end
            ST_FIN: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default:  state_n = ST_IDLE;
        endcase
    end

    // snapshot, word index, stall/latency counters and sticky error report
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap     <= '0;
            verify   <= 1'b0;
            idx      <= 4'd0;
            tcnt     <= '0;
            lcnt     <= 3'd0;
            err_code <= ERR_NONE;
            err_addr <= 4'd0;
        end else begin
            if (state == ST_IDLE && start) begin
                snap     <= '{checksum: checksum_i, local_port: local_port_i, remote_port: remote_port_i,
                              local_ip: local_IP_i, remote_ip: remote_IP_i,
                              local_mac: local_MAC_i, remote_mac: remote_MAC_i};
                verify   <= verify_en;
                idx      <= 4'd0;
                tcnt     <= '0;
                err_code <= ERR_NONE;
                err_addr <= 4'd0;
            end
            if (tmo) begin
                tcnt     <= '0;
                err_code <= ERR_TIMEOUT;
                err_addr <= idx;
            end else if (stall)
                tcnt <= tcnt + 1'b1;
            else if (accept)
                tcnt <= '0;
            if (accept && state == ST_WR)
                idx <= last ? 4'd0 : idx + 4'd1;
            if (accept && state == ST_RD)
                lcnt <= 3'd0;
            if (state == ST_RWAIT)
                lcnt <= lcnt + 3'd1;
            if (mismatch) begin
                err_code <= ERR_MISMATCH;
                err_addr <= idx;
            end else if (rd_sample && !last)
                idx <= idx + 4'd1;
        end
    end

endmodule

// File: tb/tb_av_eth_cfg_loader.sv
// tb_av_eth_cfg_loader: directed self-checking bench with a latency-1 config slave model
module tb_av_eth_cfg_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        verify_en = 1'b0;
    logic [15:0] checksum_i = 16'hABCD;
    logic [15:0] local_port_i = 16'h1234;
    logic [15:0] remote_port_i = 16'h5678;
    logic [31:0] local_IP_i = 32'hC0A80004;
    logic [31:0] remote_IP_i = 32'hC0A80005;
    logic [47:0] local_MAC_i = 48'h74EA3A851BD7;
    logic [47:0] remote_MAC_i = 48'h001122334455;
    logic [3:0]  address;
    logic        write, read, busy, done;
    logic [31:0] writedata;
    logic [31:0] readdata = 32'h0;
    logic        waitrequest = 1'b0;
    logic [1:0]  err_code;
    logic [3:0]  err_addr;

    logic        corrupt = 1'b0;
    logic [31:0] mem [0:15];
    logic [31:0] exp_w [0:8];
    int          done_cnt = 0, wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
    int          rd_hits [0:15];
    int          checks = 0, errors = 0;

    av_eth_cfg_loader dut (
        .clk(clk), .reset(reset), .start(start), .verify_en(verify_en),
        .checksum_i(checksum_i), .local_port_i(local_port_i), .remote_port_i(remote_port_i),
        .local_IP_i(local_IP_i), .remote_IP_i(remote_IP_i),
        .local_MAC_i(local_MAC_i), .remote_MAC_i(remote_MAC_i),
        .address(address), .write(write), .read(read), .writedata(writedata),
        .readdata(readdata), .waitrequest(waitrequest),
        .busy(busy), .done(done), .err_code(err_code), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    // config slave model: stores writes, returns reads one cycle after accept, optionally corrupts word 4
    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (write && read) both_cnt <= both_cnt + 1;
        if (write && !waitrequest) begin
            mem[address] <= writedata;
            wr_cnt <= wr_cnt + 1;
        end
        if (read && !waitrequest) begin
            rd_cnt <= rd_cnt + 1;
            rd_hits[address] <= rd_hits[address] + 1;
            readdata <= (corrupt && address == 4'd4) ? 32'hC0A80006 : mem[address];
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string tag);
        int n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_timeout got done=%b after %0d cycles expected 1", tag, done, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({address, write, read, writedata, busy, done, err_code, err_addr} !== 45'h0) begin
            errors++;
            $display("FAIL reset_outputs got addr=%h wr=%b rd=%b wd=%h busy=%b done=%b ec=%0d ea=%0d expected all 0",
                     address, write, read, writedata, busy, done, err_code, err_addr);
        end
        reset = 1'b0;
    endtask

    task automatic test_write_only();
        int base = wr_cnt;
        verify_en = 1'b0;
        waitrequest = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c <= 9) begin
                checks++;
                if ({write, read, busy, address, writedata} !== {3'b101, 4'(c - 1), exp_w[c - 1]}) begin
                    errors++;
                    $display("FAIL wr_beat%0d got wr=%b rd=%b busy=%b addr=%0d wd=%h expected 1 0 1 %0d %h",
                             c - 1, write, read, busy, address, writedata, c - 1, exp_w[c - 1]);
                end
            end else begin
                checks++;
                if ({done, busy, write} !== 3'b100) begin
                    errors++;
                    $display("FAIL wr_done_cycle10 got done=%b busy=%b wr=%b expected 1 0 0", done, busy, write);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || wr_cnt - base != 9) begin
            errors++;
            $display("FAIL wr_after_done got done=%b writes=%0d expected 0 9", done, wr_cnt - base);
        end
    endtask

    task automatic test_verify();
        int bd = done_cnt, br = rd_cnt, bad = 0;
        verify_en = 1'b1;
        pulse_start();
        wait_done(100, "verify");
        checks++;
        if (err_code !== 2'd0) begin
            errors++;
            $display("FAIL verify_err_code got %0d expected 0", err_code);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 9; i++) if (mem[i] !== exp_w[i]) bad++;
        checks++;
        if (done_cnt - bd != 1 || rd_cnt - br != 9 || both_cnt != 0 || bad != 0) begin
            errors++;
            $display("FAIL verify_counts got dones=%0d reads=%0d overlap=%0d badwords=%0d expected 1 9 0 0",
                     done_cnt - bd, rd_cnt - br, both_cnt, bad);
        end
    endtask

    task automatic test_mismatch();
        int bd = done_cnt, h4 = rd_hits[4], h5 = rd_hits[5];
        verify_en = 1'b1;
        corrupt = 1'b1;
        pulse_start();
        wait_done(100, "mismatch");
        checks++;
        if (err_code !== 2'd1 || err_addr !== 4'd4) begin
            errors++;
            $display("FAIL mismatch_err got ec=%0d ea=%0d expected 1 4", err_code, err_addr);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (rd_hits[5] != h5 || rd_hits[4] - h4 != 1 || done_cnt - bd != 1) begin
            errors++;
            $display("FAIL mismatch_abort got reads5=%0d reads4=%0d dones=%0d expected 0 1 1",
                     rd_hits[5] - h5, rd_hits[4] - h4, done_cnt - bd);
        end
        corrupt = 1'b0;
    endtask

    task automatic test_stall();
        int base = wr_cnt;
        verify_en = 1'b0;
        mem[2] = 32'h0;
        pulse_start();
        repeat (2) @(negedge clk);
        waitrequest = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({write, address, writedata} !== {1'b1, 4'd2, exp_w[2]}) begin
                errors++;
                $display("FAIL stall_hold%0d got wr=%b addr=%0d wd=%h expected 1 2 %h",
                         k, write, address, writedata, exp_w[2]);
            end
            if (k == 2) waitrequest = 1'b0;
        end
        wait_done(100, "stall");
        checks++;
        if (err_code !== 2'd0 || wr_cnt - base != 9 || mem[2] !== exp_w[2]) begin
            errors++;
            $display("FAIL stall_result got ec=%0d writes=%0d word2=%h expected 0 9 %h",
                     err_code, wr_cnt - base, mem[2], exp_w[2]);
        end
    endtask

    task automatic test_timeout();
        int n = 0, base = wr_cnt;
        verify_en = 1'b0;
        waitrequest = 1'b1;
        pulse_start();
        while (write && n < 400) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 255 || done !== 1'b1) begin
            errors++;
            $display("FAIL timeout_len got stall_cycles=%0d done=%b expected 255 1", n, done);
        end
        checks++;
        if (err_code !== 2'd2 || err_addr !== 4'd0 || wr_cnt != base) begin
            errors++;
            $display("FAIL timeout_err got ec=%0d ea=%0d writes=%0d expected 2 0 0", err_code, err_addr, wr_cnt - base);
        end
        waitrequest = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_busy_start();
        int bd = done_cnt, bw = wr_cnt;
        verify_en = 1'b0;
        pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100, "busy_start");
        repeat (20) @(negedge clk);
        checks++;
        if (done_cnt - bd != 1 || wr_cnt - bw != 9 || busy !== 1'b0 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL busy_start_ignored got dones=%0d writes=%0d busy=%b ec=%0d expected 1 9 0 0",
                     done_cnt - bd, wr_cnt - bw, busy, err_code);
        end
    endtask

    task automatic test_reset_mid();
        int bd, bw = wr_cnt;
        verify_en = 1'b0;
        pulse_start();
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (write !== 1'b1 || address !== 4'd5) begin
            errors++;
            $display("FAIL reset_mid_pos got wr=%b addr=%0d expected 1 5", write, address);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({address, write, read, writedata, busy, done} !== 40'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs got addr=%0d wr=%b rd=%b wd=%h busy=%b done=%b expected all 0",
                     address, write, read, writedata, busy, done);
        end
        bd = done_cnt;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (done_cnt != bd || busy !== 1'b0 || wr_cnt - bw != 5) begin
            errors++;
            $display("FAIL reset_mid_after got dones=%0d busy=%b writes=%0d expected 0 0 5",
                     done_cnt - bd, busy, wr_cnt - bw);
        end
    endtask

    initial begin
        exp_w[0] = 32'h0000ABCD;
        exp_w[1] = 32'h00001234;
        exp_w[2] = 32'h00005678;
        exp_w[3] = 32'hC0A80004;
        exp_w[4] = 32'hC0A80005;
        exp_w[5] = 32'h3A851BD7;
        exp_w[6] = 32'h000074EA;
        exp_w[7] = 32'h22334455;
        exp_w[8] = 32'h00000011;
        for (int i = 0; i < 16; i++) begin
            mem[i] = 32'h0;
            rd_hits[i] = 0;
        end
        test_reset();
        test_write_only();
        test_verify();
        test_mismatch();
        test_stall();
        test_timeout();
        test_busy_start();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
